// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one single-port memory between the instruction-fetch (IF)
// and load/store (LS) requesters. Grants are combinational, read data is
// registered into a per-port response one cycle after the grant.
// Optional macro ARB_RR_EN selects round-robin arbitration; when it is left
// undefined the arbiter uses fixed LS-over-IF priority with an IF starvation
// counter that forces an IF grant after STARVE_LIMIT refused cycles.
module mem_arbiter #(
  parameter int ADDR_W       = 30,
  parameter int DATA_W       = 32,
  parameter int STARVE_LIMIT = 4
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_if_req,
  input  logic [ADDR_W-1:0] i_if_addr,
  output logic              o_if_gnt,
  output logic              o_if_rvalid,
  output logic [DATA_W-1:0] o_if_rdata,
  input  logic              i_ls_req,
  input  logic              i_ls_we,
  input  logic [ADDR_W-1:0] i_ls_addr,
  input  logic [3:0]        i_ls_sel,
  input  logic [DATA_W-1:0] i_ls_wdata,
  output logic              o_ls_gnt,
  output logic              o_ls_rvalid,
  output logic [DATA_W-1:0] o_ls_rdata,
  output logic [ADDR_W-1:0] o_mem_address,
  output logic [3:0]        o_mem_sel_width,
  output logic              o_mem_w_en,
  output logic [DATA_W-1:0] o_mem_din,
  input  logic [DATA_W-1:0] i_mem_dout
);

  // last_reg: port that received the most recent grant (0 = IF, 1 = LS)
  logic              last_reg;
  logic              if_rvalid_reg;
  logic              ls_rvalid_reg;
  logic [DATA_W-1:0] if_rdata_reg;
  logic [DATA_W-1:0] ls_rdata_reg;

  // if_wins: IF takes the memory when both ports request in the same cycle
  logic if_wins;

`ifdef ARB_RR_EN
  // Round-robin: under contention the port that did not win last time goes.
  assign if_wins = last_reg;
`else
  localparam int CNT_W = (STARVE_LIMIT < 1) ? 1 : $clog2(STARVE_LIMIT + 1);
  localparam logic [CNT_W-1:0] STARVE_MAX = CNT_W'(STARVE_LIMIT);

  logic [CNT_W-1:0] starve_reg;

  // Fixed priority: LS wins unless IF has already been refused STARVE_LIMIT times.
  assign if_wins = (starve_reg == STARVE_MAX);

  // Count consecutive cycles IF waits while requesting; saturate at the limit.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      starve_reg <= '0;
    end else if (!i_if_req || o_if_gnt) begin
      starve_reg <= '0;
    end else if (starve_reg != STARVE_MAX) begin
      starve_reg <= starve_reg + 1'b1;
    end
  end
`endif

  // Grants are suppressed during reset so no access (and no write) can slip through.
  assign o_if_gnt = !i_rst && i_if_req && (!i_ls_req || if_wins);
  assign o_ls_gnt = !i_rst && i_ls_req && (!i_if_req || !if_wins);

  // Steer the winning port onto the memory bus; idle bus is all zeros.
  always_comb begin
    o_mem_address   = '0;
    o_mem_sel_width = 4'b0000;
    o_mem_w_en      = 1'b0;
    o_mem_din       = '0;
    if (o_if_gnt) begin
      o_mem_address   = i_if_addr;
      o_mem_sel_width = 4'b1111;
    end else if (o_ls_gnt) begin
      o_mem_address   = i_ls_addr;
      o_mem_sel_width = i_ls_sel;
      o_mem_w_en      = i_ls_we;
      o_mem_din       = i_ls_wdata;
    end
  end

  // Track the last winner and capture async read data into per-port responses.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      last_reg      <= 1'b0;
      if_rvalid_reg <= 1'b0;
      ls_rvalid_reg <= 1'b0;
      if_rdata_reg  <= '0;
      ls_rdata_reg  <= '0;
    end else begin
      if_rvalid_reg <= o_if_gnt;
      ls_rvalid_reg <= o_ls_gnt && !i_ls_we;
      if (o_if_gnt) begin
        last_reg     <= 1'b0;
        if_rdata_reg <= i_mem_dout;
      end
      if (o_ls_gnt) begin
        last_reg <= 1'b1;
        if (!i_ls_we) begin
          ls_rdata_reg <= i_mem_dout;
        end
      end
    end
  end

  assign o_if_rvalid = if_rvalid_reg;
  assign o_if_rdata  = if_rdata_reg;
  assign o_ls_rvalid = ls_rvalid_reg;
  assign o_ls_rdata  = ls_rdata_reg;

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed bench for mem_arbiter with a small byte-lane memory
// model (async masked read, byte-enabled write on the clock edge).
module tb_mem_arbiter;

  logic        clk;
  logic        rst;
  logic        if_req;
  logic [29:0] if_addr;
  logic        if_gnt;
  logic        if_rvalid;
  logic [31:0] if_rdata;
  logic        ls_req;
  logic        ls_we;
  logic [29:0] ls_addr;
  logic [3:0]  ls_sel;
  logic [31:0] ls_wdata;
  logic        ls_gnt;
  logic        ls_rvalid;
  logic [31:0] ls_rdata;
  logic [29:0] mem_address;
  logic [3:0]  mem_sel_width;
  logic        mem_w_en;
  logic [31:0] mem_din;
  logic [31:0] mem_dout;

  logic        init_mem;
  logic [31:0] mem [0:255];

  int checks = 0;
  int errors = 0;

  mem_arbiter #(.ADDR_W(30), .DATA_W(32), .STARVE_LIMIT(4)) dut (
    .i_clk(clk), .i_rst(rst),
    .i_if_req(if_req), .i_if_addr(if_addr), .o_if_gnt(if_gnt),
    .o_if_rvalid(if_rvalid), .o_if_rdata(if_rdata),
    .i_ls_req(ls_req), .i_ls_we(ls_we), .i_ls_addr(ls_addr),
    .i_ls_sel(ls_sel), .i_ls_wdata(ls_wdata), .o_ls_gnt(ls_gnt),
    .o_ls_rvalid(ls_rvalid), .o_ls_rdata(ls_rdata),
    .o_mem_address(mem_address), .o_mem_sel_width(mem_sel_width),
    .o_mem_w_en(mem_w_en), .o_mem_din(mem_din), .i_mem_dout(mem_dout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory model: preload 0xA0+index (word 0x20 holds 0x12345678), byte writes.
  always @(posedge clk) begin
    if (init_mem) begin
      for (int i = 0; i < 256; i++) mem[i] <= 32'hA0 + i;
      mem[8'h20] <= 32'h1234_5678;
    end else if (mem_w_en) begin
      for (int b = 0; b < 4; b++)
        if (mem_sel_width[b]) mem[mem_address[7:0]][b*8 +: 8] <= mem_din[b*8 +: 8];
    end
  end

  // Async masked read.
  always_comb begin
    mem_dout = 32'h0;
    for (int b = 0; b < 4; b++)
      if (mem_sel_width[b]) mem_dout[b*8 +: 8] = mem[mem_address[7:0]][b*8 +: 8];
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic mid();
    @(negedge clk);
  endtask

  task automatic next();
    @(posedge clk);
    #1;
  endtask

  logic exp_ls;

  initial begin
    // Reset with both requesters active and LS asking to write.
    rst = 1'b1; init_mem = 1'b1;
    if_req = 1'b1; if_addr = 30'h5;
    ls_req = 1'b1; ls_we = 1'b1; ls_addr = 30'h30; ls_sel = 4'b1111; ls_wdata = 32'hFFFF_FFFF;
    #1;
    for (int c = 0; c < 3; c++) begin
      mid();
      chk($sformatf("rst_if_gnt_%0d", c), if_gnt, 1'b0);
      chk($sformatf("rst_ls_gnt_%0d", c), ls_gnt, 1'b0);
      chk($sformatf("rst_w_en_%0d", c), mem_w_en, 1'b0);
      chk($sformatf("rst_addr_%0d", c), mem_address, 30'h0);
      if (c > 0) begin
        chk($sformatf("rst_if_rvalid_%0d", c), if_rvalid, 1'b0);
        chk($sformatf("rst_ls_rvalid_%0d", c), ls_rvalid, 1'b0);
        chk($sformatf("rst_if_rdata_%0d", c), if_rdata, 32'h0);
        chk($sformatf("rst_ls_rdata_%0d", c), ls_rdata, 32'h0);
      end
      next();
      init_mem = 1'b0;
    end
    chk("rst_no_write", mem[8'h30], 32'hD0);
    $display("reset: 3 cycles, both requests held, no grant");

    // First cycle after release: exactly one grant (LS in both modes).
    rst = 1'b0; ls_we = 1'b0;
    mid();
    chk("release_one_gnt", 32'(if_gnt) + 32'(ls_gnt), 32'd1);
    chk("release_ls_gnt", ls_gnt, 1'b1);
    chk("release_addr", mem_address, 30'h30);
    next();
    if_req = 1'b0; ls_req = 1'b0;
    mid();
    chk("release_ls_rvalid", ls_rvalid, 1'b1);
    chk("release_ls_rdata", ls_rdata, 32'hD0);
    $display("release: LS read 0x30 -> %h", ls_rdata);
    next();

    // IF alone, back-to-back reads of 0x10..0x12.
    for (int k = 0; k < 4; k++) begin
      if_req = (k < 3); if_addr = 30'h10 + 30'(k);
      mid();
      chk($sformatf("if_gnt_%0d", k), if_gnt, (k < 3) ? 1'b1 : 1'b0);
      if (k < 3) begin
        chk($sformatf("if_addr_%0d", k), mem_address, 30'h10 + 30'(k));
        chk($sformatf("if_sel_%0d", k), mem_sel_width, 4'b1111);
        chk($sformatf("if_w_en_%0d", k), mem_w_en, 1'b0);
      end
      if (k > 0) begin
        chk($sformatf("if_rvalid_%0d", k), if_rvalid, 1'b1);
        chk($sformatf("if_rdata_%0d", k), if_rdata, 32'hB0 + 32'(k - 1));
        $display("IF read %0d: rdata=%h", k - 1, if_rdata);
      end
      next();
    end
    mid();
    chk("if_rvalid_end", if_rvalid, 1'b0);
    chk("if_rdata_hold", if_rdata, 32'hB2);
    next();

    // LS partial write then full read of the same word.
    ls_req = 1'b1; ls_we = 1'b1; ls_addr = 30'h20; ls_sel = 4'b0011; ls_wdata = 32'hDEAD_BEEF;
    mid();
    chk("wr_gnt", ls_gnt, 1'b1);
    chk("wr_w_en", mem_w_en, 1'b1);
    chk("wr_sel", mem_sel_width, 4'b0011);
    chk("wr_din", mem_din, 32'hDEAD_BEEF);
    chk("wr_addr", mem_address, 30'h20);
    next();
    ls_we = 1'b0; ls_sel = 4'b1111; ls_wdata = 32'h0;
    mid();
    chk("wr_no_rvalid", ls_rvalid, 1'b0);
    chk("wr_rdata_hold", ls_rdata, 32'hD0);
    chk("rd_gnt", ls_gnt, 1'b1);
    chk("rd_w_en", mem_w_en, 1'b0);
    next();
    ls_req = 1'b0;
    mid();
    chk("rd_rvalid", ls_rvalid, 1'b1);
    chk("rd_rdata", ls_rdata, 32'h1234_BEEF);
    $display("LS write 0x20 sel=0011 then read -> %h", ls_rdata);
    next();

    // Contention from a fresh reset: both reads held for 10 cycles.
    rst = 1'b1;
    next();
    rst = 1'b0;
    if_req = 1'b1; if_addr = 30'h40;
    ls_req = 1'b1; ls_we = 1'b0; ls_addr = 30'h41; ls_sel = 4'b1111;
    for (int c = 0; c < 10; c++) begin
`ifdef ARB_RR_EN
      exp_ls = (c % 2 == 0);
`else
      exp_ls = !(c == 4 || c == 9);
`endif
      mid();
      chk($sformatf("cont_ls_gnt_%0d", c), ls_gnt, exp_ls);
      chk($sformatf("cont_if_gnt_%0d", c), if_gnt, !exp_ls);
      chk($sformatf("cont_addr_%0d", c), mem_address, exp_ls ? 30'h41 : 30'h40);
      $display("contention cycle %0d: if_gnt=%0b ls_gnt=%0b", c, if_gnt, ls_gnt);
      next();
    end
    if_req = 1'b0; ls_req = 1'b0;
    next();

    // Reset right after an IF read grant clears the pending response.
    if_req = 1'b1; if_addr = 30'h50;
    mid();
    chk("rstmid_if_gnt", if_gnt, 1'b1);
    next();
    if_req = 1'b0; rst = 1'b1;
    mid();
    chk("rstmid_no_gnt", if_gnt, 1'b0);
    next();
    rst = 1'b0;
    mid();
    chk("rstmid_if_rvalid", if_rvalid, 1'b0);
    chk("rstmid_if_rdata", if_rdata, 32'h0);
    chk("rstmid_ls_rdata", ls_rdata, 32'h0);
    $display("reset after IF grant: rvalid=%0b rdata=%h", if_rvalid, if_rdata);
    next();

    // Idle: bus quiet, memory untouched.
    ls_we = 1'b1; ls_wdata = 32'hFFFF_FFFF;
    for (int c = 0; c < 5; c++) begin
      mid();
      chk($sformatf("idle_w_en_%0d", c), mem_w_en, 1'b0);
      chk($sformatf("idle_addr_%0d", c), mem_address, 30'h0);
      chk($sformatf("idle_sel_%0d", c), mem_sel_width, 4'b0000);
      chk($sformatf("idle_gnt_%0d", c), 32'(if_gnt) + 32'(ls_gnt), 32'd0);
      next();
    end
    chk("idle_mem_20", mem[8'h20], 32'h1234_BEEF);
    chk("idle_mem_41", mem[8'h41], 32'hE1);
    chk("idle_mem_10", mem[8'h10], 32'hB0);
    $display("idle: 5 cycles, bus quiet");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
